mem_port_arbiter: RTL and testbench

//  Shares the single-ported mem_controller between instruction fetch (IF) and the

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported memory controller between instruction fetch (IF)
// and the data stage (DM); DM has priority, a starvation counter guarantees IF progress.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wren,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  grant_dm_q, grant_dm_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  mem_wren_q, mem_wren_d;
    logic [31:0]           if_rdata_q, if_rdata_d;
    logic [31:0]           dm_rdata_q, dm_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  dm_ack_q, dm_ack_d;
    logic                  busy_q, busy_d;
    logic                  if_forced;

    // IF is forced through only once DM has won STARVE_LIMIT times over a waiting IF.
    assign if_forced = if_req && (starve_q == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        grant_dm_d  = grant_dm_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = mem_wren_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (if_req || dm_req) begin
                    cnt_d   = CNT_W'(MEM_LATENCY);
                    state_d = ACCESS;
                    if (dm_req && !if_forced) begin
                        grant_dm_d  = 1'b1;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_wren_d  = dm_we;
                        if (if_req && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end else begin
                        grant_dm_d = 1'b0;
                        mem_addr_d = if_addr;
                        mem_wren_d = 1'b0;
                        starve_d   = '0;
                    end
                end
            end

            ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Write data is never captured back; only reads update rdata.
                    if (!mem_wren_q) begin
                        if (grant_dm_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    mem_wren_d = 1'b0;
                    if_ack_d   = !grant_dm_q;
                    dm_ack_d   = grant_dm_q;
                    state_d    = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d    = IDLE;
                mem_wren_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            grant_dm_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            grant_dm_q  <= grant_dm_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wren  = mem_wren_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-1 instance driven from a vector table and
// a latency-3 instance exercised with hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    logic clock;
    logic reset_n;

    // Latency-1 instance signals
    logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack, a_mem_wren, a_busy;
    logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Latency-3 instance signals
    logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack, b_mem_wren, b_busy;
    logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int checkCount;
    int passCount;

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_l1 (
        .clock(clock), .reset_n(reset_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
        .mem_addr(a_mem_addr), .mem_wren(a_mem_wren), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_l3 (
        .clock(clock), .reset_n(reset_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_addr(b_mem_addr), .mem_wren(b_mem_wren), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One table row: inputs applied before an edge, outputs expected just after it
    typedef struct {
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dmReq;
        logic        dmWe;
        logic [31:0] dmAddr;
        logic [31:0] dmWdata;
        logic [31:0] memRdata;
        logic        expIfAck;
        logic        expDmAck;
        logic        expBusy;
        logic        expWren;
        logic [31:0] expMemAddr;
        logic [31:0] expIfRdata;
        logic [31:0] expDmRdata;
    } vec_t;

    vec_t vecs[13];

    // Compares one observed value against its expected value and tallies it
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one table row onto the latency-1 instance
    task automatic applyStimulus(input vec_t v);
        a_if_req    = v.ifReq;
        a_if_addr   = v.ifAddr;
        a_dm_req    = v.dmReq;
        a_dm_we     = v.dmWe;
        a_dm_addr   = v.dmAddr;
        a_dm_wdata  = v.dmWdata;
        a_mem_rdata = v.memRdata;
    endtask

    // Advances to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mkVec(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr,
        input logic eia, input logic eda, input logic eb, input logic ew,
        input logic [31:0] ema, input logic [31:0] eir, input logic [31:0] edr);
        vec_t v;
        v.ifReq = ir; v.ifAddr = ia; v.dmReq = dr; v.dmWe = dw;
        v.dmAddr = da; v.dmWdata = dd; v.memRdata = mr;
        v.expIfAck = eia; v.expDmAck = eda; v.expBusy = eb; v.expWren = ew;
        v.expMemAddr = ema; v.expIfRdata = eir; v.expDmRdata = edr;
        return v;
    endfunction

    int grants[10];
    int nGrants;
    int cyc;

    initial begin
        checkCount = 0;
        passCount  = 0;

        // Fetch read, then simultaneous IF/DM, then a DM write on the latency-1 port
        //                 ifReq ifAddr     dmReq we dmAddr     dmWdata      memRdata      ifAk dmAk busy wren memAddr    ifRdata       dmRdata
        vecs[0]  = mkVec(1, 32'h100, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 1, 0, 32'h100, 32'h0,        32'h0);
        vecs[1]  = mkVec(1, 32'h100, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, 1, 0, 1, 0, 32'h100, 32'hDEADBEEF, 32'h0);
        vecs[2]  = mkVec(0, 32'h100, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 32'h0);
        vecs[3]  = mkVec(0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 32'h0);
        vecs[4]  = mkVec(1, 32'h300, 1, 0, 32'h200, 32'h0,        32'h0,        0, 0, 1, 0, 32'h200, 32'hDEADBEEF, 32'h0);
        vecs[5]  = mkVec(1, 32'h300, 1, 0, 32'h200, 32'h0,        32'hCAFE0001, 0, 1, 1, 0, 32'h200, 32'hDEADBEEF, 32'hCAFE0001);
        vecs[6]  = mkVec(1, 32'h300, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0, 32'h200, 32'hDEADBEEF, 32'hCAFE0001);
        vecs[7]  = mkVec(1, 32'h300, 0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 1, 0, 32'h300, 32'hDEADBEEF, 32'hCAFE0001);
        vecs[8]  = mkVec(1, 32'h300, 0, 0, 32'h0,   32'h0,        32'h0BADF00D, 1, 0, 1, 0, 32'h300, 32'h0BADF00D, 32'hCAFE0001);
        vecs[9]  = mkVec(0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0, 32'h300, 32'h0BADF00D, 32'hCAFE0001);
        vecs[10] = mkVec(0, 32'h0,   1, 1, 32'h400, 32'h11112222, 32'h0,        0, 0, 1, 1, 32'h400, 32'h0BADF00D, 32'hCAFE0001);
        vecs[11] = mkVec(0, 32'h0,   1, 1, 32'h400, 32'h11112222, 32'h99999999, 0, 1, 1, 0, 32'h400, 32'h0BADF00D, 32'hCAFE0001);
        vecs[12] = mkVec(0, 32'h0,   0, 0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0, 32'h400, 32'h0BADF00D, 32'hCAFE0001);

        reset_n = 1'b0;
        a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = 0; a_dm_wdata = 0; a_mem_rdata = 0;
        b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0; b_mem_rdata = 0;
        #2;
        checkOutput("reset_busy",     {31'b0, a_busy},     32'h0);
        checkOutput("reset_wren",     {31'b0, a_mem_wren}, 32'h0);
        checkOutput("reset_mem_addr", a_mem_addr,          32'h0);
        checkOutput("reset_acks",     {30'b0, a_if_ack, a_dm_ack}, 32'h0);
        checkOutput("reset_if_rdata", a_if_rdata,          32'h0);
        checkOutput("reset_b_busy",   {31'b0, b_busy},     32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Table-driven part on the latency-1 instance
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("v%0d_if_ack", i),   {31'b0, a_if_ack},   {31'b0, vecs[i].expIfAck});
            checkOutput($sformatf("v%0d_dm_ack", i),   {31'b0, a_dm_ack},   {31'b0, vecs[i].expDmAck});
            checkOutput($sformatf("v%0d_busy", i),     {31'b0, a_busy},     {31'b0, vecs[i].expBusy});
            checkOutput($sformatf("v%0d_wren", i),     {31'b0, a_mem_wren}, {31'b0, vecs[i].expWren});
            checkOutput($sformatf("v%0d_mem_addr", i), a_mem_addr,          vecs[i].expMemAddr);
            checkOutput($sformatf("v%0d_if_rdata", i), a_if_rdata,          vecs[i].expIfRdata);
            checkOutput($sformatf("v%0d_dm_rdata", i), a_dm_rdata,          vecs[i].expDmRdata);
        end
        checkOutput("wr_mem_wdata", a_mem_wdata, 32'h11112222);

        // Anti-starvation: both requesters held high, expect DM x4 then IF, repeating
        for (int i = 0; i < 10; i++) grants[i] = 2;
        nGrants = 0;
        a_if_req = 1; a_if_addr = 32'h700;
        a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h800;
        a_mem_rdata = 32'h5;
        cyc = 0;
        while (nGrants < 10 && cyc < 200) begin
            step();
            cyc++;
            checkOutput("ack_overlap", {31'b0, a_if_ack & a_dm_ack}, 32'h0);
            if (a_dm_ack) begin
                grants[nGrants] = 1;
                nGrants++;
            end else if (a_if_ack) begin
                grants[nGrants] = 0;
                nGrants++;
            end
        end
        a_if_req = 0;
        a_dm_req = 0;
        checkOutput("starve_grant_count", nGrants, 10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("starve_grant%0d", i), grants[i], (i % 5 == 4) ? 0 : 1);
        end
        repeat (3) step();

        // Latency-3 read to give dm_rdata a known value
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = 32'h40; b_mem_rdata = 32'h55AA55AA;
        for (int k = 1; k <= 3; k++) begin
            step();
            checkOutput($sformatf("l3rd_c%0d_busy", k), {31'b0, b_busy}, 32'h1);
            checkOutput($sformatf("l3rd_c%0d_ack", k),  {31'b0, b_dm_ack}, 32'h0);
        end
        step();
        checkOutput("l3rd_ack",    {31'b0, b_dm_ack}, 32'h1);
        checkOutput("l3rd_rdata",  b_dm_rdata, 32'h55AA55AA);
        b_dm_req = 0;
        step();
        checkOutput("l3rd_idle",   {31'b0, b_busy}, 32'h0);

        // Latency-3 write: wren exactly cycles 1-3, ack cycle 4, dm_rdata untouched
        b_dm_req = 1; b_dm_we = 1; b_dm_addr = 32'h2000; b_dm_wdata = 32'h12345678;
        b_mem_rdata = 32'hFFFFFFFF;
        for (int k = 1; k <= 3; k++) begin
            step();
            checkOutput($sformatf("l3wr_c%0d_wren", k),  {31'b0, b_mem_wren}, 32'h1);
            checkOutput($sformatf("l3wr_c%0d_addr", k),  b_mem_addr,  32'h2000);
            checkOutput($sformatf("l3wr_c%0d_wdata", k), b_mem_wdata, 32'h12345678);
            checkOutput($sformatf("l3wr_c%0d_ack", k),   {31'b0, b_dm_ack}, 32'h0);
        end
        step();
        checkOutput("l3wr_ack",   {31'b0, b_dm_ack},   32'h1);
        checkOutput("l3wr_wren4", {31'b0, b_mem_wren}, 32'h0);
        checkOutput("l3wr_rdata", b_dm_rdata, 32'h55AA55AA);
        b_dm_req = 0; b_dm_we = 0;
        step();
        checkOutput("l3wr_ack_pulse", {31'b0, b_dm_ack}, 32'h0);
        checkOutput("l3wr_idle_addr", b_mem_addr, 32'h2000);

        // Write whose requester drops req after the first access cycle
        b_dm_req = 1; b_dm_we = 1; b_dm_addr = 32'h3000; b_dm_wdata = 32'hA5A5A5A5;
        step();
        checkOutput("drop_c1_wren", {31'b0, b_mem_wren}, 32'h1);
        b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
        for (int k = 2; k <= 3; k++) begin
            step();
            checkOutput($sformatf("drop_c%0d_wren", k), {31'b0, b_mem_wren}, 32'h1);
            checkOutput($sformatf("drop_c%0d_addr", k), b_mem_addr, 32'h3000);
        end
        step();
        checkOutput("drop_ack",  {31'b0, b_dm_ack},   32'h1);
        checkOutput("drop_wren", {31'b0, b_mem_wren}, 32'h0);
        step();

        // Reset asserted in ACCESS cycle 2 of a write, then a fresh access
        b_dm_req = 1; b_dm_we = 1; b_dm_addr = 32'h600; b_dm_wdata = 32'h0F0F0F0F;
        step();
        step();
        checkOutput("rst_pre_wren", {31'b0, b_mem_wren}, 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_wren_now", {31'b0, b_mem_wren}, 32'h0);
        checkOutput("rst_busy_now", {31'b0, b_busy},     32'h0);
        checkOutput("rst_addr_now", b_mem_addr,          32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("rst_hold%0d_ack", k), {30'b0, b_if_ack, b_dm_ack}, 32'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checkOutput($sformatf("rst_new_c%0d_wren", k), {31'b0, b_mem_wren}, 32'h1);
            checkOutput($sformatf("rst_new_c%0d_ack", k),  {31'b0, b_dm_ack},   32'h0);
        end
        checkOutput("rst_new_addr", b_mem_addr, 32'h600);
        step();
        checkOutput("rst_new_ack", {31'b0, b_dm_ack}, 32'h1);
        b_dm_req = 0; b_dm_we = 0;
        step();
        checkOutput("rst_new_idle", {31'b0, b_busy}, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
